// File: rtl/sw_key_pkg.sv
// sw_key_pkg -- shared definitions for the switch debounce / key scan block.
//
// Contents:
//   key_state_t      per-key debounce FSM state encoding
//   MODE_*           mode codes reported by sw_key_scan (0 = none, 1..3 = key index+1)
//   DEBOUNCE_DEFAULT default stable-sample count (20 ms at 50 MHz)
//   mode_encode()    lowest-index-wins priority encode of a press vector
//
// Optional feature macro used by the block: SW_KEY_RELEASE_EN (see sw_key_chan).
package sw_key_pkg;

    typedef enum logic [1:0] {
        KEY_IDLE         = 2'd0,
        KEY_PRESS_WAIT   = 2'd1,
        KEY_HELD         = 2'd2,
        KEY_RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam logic [1:0] MODE_NONE = 2'd0;
    localparam logic [1:0] MODE_K1   = 2'd1;
    localparam logic [1:0] MODE_K2   = 2'd2;
    localparam logic [1:0] MODE_K3   = 2'd3;

    localparam int DEBOUNCE_DEFAULT = 1_000_000;

    // Key 1 outranks key 2, which outranks key 3.
    function automatic logic [1:0] mode_encode(input logic [2:0] press);
        if (press[0])      return MODE_K1;
        else if (press[1]) return MODE_K2;
        else if (press[2]) return MODE_K3;
        else               return MODE_NONE;
    endfunction

endpackage

// File: rtl/sw_key_chan.sv
// sw_key_chan -- one debounced key channel.
//
// Synchronizes an active-low bouncing switch, then runs a four-state
// debounce FSM (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT) that requires
// DEBOUNCE_CYCLES consecutive identical synchronized samples before
// accepting a transition.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   sw_n        raw asynchronous switch, active-low
//   sw_level    debounced state, 1 = held
//   sw_press    one-cycle pulse per accepted press
//   sw_release  one-cycle pulse per accepted release (0 unless SW_KEY_RELEASE_EN)
//   press_set   combinational "press accepted on this edge" (feeds mode register)
//   state_dbg   current FSM state
//
// Macro: SW_KEY_RELEASE_EN -- when defined, sw_release is driven; otherwise it
// is tied to 0 while release debouncing still governs sw_level.
module sw_key_chan
    import sw_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_n,
    output logic       sw_level,
    output logic       sw_press,
    output logic       sw_release,
    output logic       press_set,
    output logic [1:0] state_dbg
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // The sample that moves IDLE->PRESS_WAIT (or HELD->RELEASE_WAIT) is the
    // first stable sample, with the counter at 0. The counter therefore reads
    // N-2 when the N-th consecutive sample arrives.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pressed;
    key_state_t             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   release_set;
    logic                   level_q;
    logic                   press_q;

    // Synchronizer loads 1 (released) on reset.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], sw_n};
    end

    assign pressed = ~sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_set   = 1'b0;
        release_set = 1'b0;
        unique case (state_q)
            KEY_IDLE: begin
                if (pressed) begin
                    state_d = KEY_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            KEY_PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = KEY_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = KEY_HELD;
                    cnt_d     = '0;
                    press_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            KEY_HELD: begin
                if (!pressed) begin
                    state_d = KEY_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            KEY_RELEASE_WAIT: begin
                if (pressed) begin
                    state_d = KEY_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = KEY_IDLE;
                    cnt_d       = '0;
                    release_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = KEY_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= KEY_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_set;
            if (press_set)        level_q <= 1'b1;
            else if (release_set) level_q <= 1'b0;
        end
    end

`ifdef SW_KEY_RELEASE_EN
    logic release_q;

    always_ff @(posedge clk) begin
        if (rst) release_q <= 1'b0;
        else     release_q <= release_set;
    end

    assign sw_release = release_q;
`else
    assign sw_release = 1'b0;
`endif

    assign sw_level  = level_q;
    assign sw_press  = press_q;
    assign state_dbg = state_q;

endmodule

// File: rtl/sw_key_scan.sv
// sw_key_scan -- debounced key scanner with latched mode selection.
//
// Instantiates one sw_key_chan per key and keeps a mode register that
// loads (lowest pressing key index)+1 whenever any key press is accepted.
// Releases never change mode.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   sw_n         raw switches, active-low, bouncing   [NUM_KEYS]
//   sw_level     debounced state, 1 = held            [NUM_KEYS]
//   sw_press     one-cycle press pulses               [NUM_KEYS]
//   sw_release   one-cycle release pulses             [NUM_KEYS]
//   mode         latched selection (0 none, 1..3)
//   mode_strobe  one-cycle pulse when mode is loaded
//   key_state    per-key FSM state, 2 bits per key (key k at [2k+1:2k])
//
// Macro: SW_KEY_RELEASE_EN -- enables the sw_release pulses.
module sw_key_scan
    import sw_key_pkg::*;
#(
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_KEYS-1:0]   sw_n,
    output logic [NUM_KEYS-1:0]   sw_level,
    output logic [NUM_KEYS-1:0]   sw_press,
    output logic [NUM_KEYS-1:0]   sw_release,
    output logic [1:0]            mode,
    output logic                  mode_strobe,
    output logic [2*NUM_KEYS-1:0] key_state
);

    logic [NUM_KEYS-1:0] press_set;
    logic [2:0]          press_pad;
    logic [1:0]          mode_q;
    logic                strobe_q;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        sw_key_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .sw_n       (sw_n[k]),
            .sw_level   (sw_level[k]),
            .sw_press   (sw_press[k]),
            .sw_release (sw_release[k]),
            .press_set  (press_set[k]),
            .state_dbg  (key_state[2*k +: 2])
        );
    end

    always_comb begin
        press_pad                 = '0;
        press_pad[NUM_KEYS-1:0]   = press_set;
    end

    // press_set is the same-edge condition that registers sw_press, so mode
    // and mode_strobe change on the edge the press pulse appears.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_NONE;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= |press_set;
            if (|press_set) mode_q <= mode_encode(press_pad);
        end
    end

    assign mode        = mode_q;
    assign mode_strobe = strobe_q;

endmodule

// File: doc/sw_key_scan.md
SW_KEY_SCAN -- requirements
Module: sw_key_scan

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 3: number of raw switch inputs, legal range 1..3.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000: stable-sample count, 20 ms at 50 MHz, minimum 2.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: input synchronizer depth, minimum 2.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port sw_n  input  NUM_KEYS  raw asynchronous switches, active-low, bouncing.
REQ-007 SHALL have port sw_level  output  NUM_KEYS  debounced state, 1 = held.
REQ-008 SHALL have port sw_press  output  NUM_KEYS  one-cycle pulse per debounced press.
REQ-009 SHALL have port sw_release  output  NUM_KEYS  one-cycle pulse per debounced release.
REQ-010 SHALL have port mode  output  2  latched selection: 0 none, 1..3 = last selecting key index+1.
REQ-011 SHALL have port mode_strobe  output  1  one-cycle pulse when mode is updated.

Function
REQ-012 SHALL pass each sw_n bit through SYNC_STAGES flops before any use.
REQ-013 SHALL run one 4-state FSM per key: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-014 IDLE: synchronized pressed -> PRESS_WAIT with counter cleared; otherwise stay.
REQ-015 PRESS_WAIT: counter increments each cycle pressed; any released sample -> IDLE, counter cleared, no output.
REQ-016 PRESS_WAIT: on the DEBOUNCE_CYCLES-th consecutive pressed sample -> HELD; sw_level set and sw_press pulsed on that same edge.
REQ-017 HELD/RELEASE_WAIT SHALL mirror REQ-014..016 for released samples; completion -> IDLE, sw_level cleared, sw_release pulsed.
REQ-018 Total latency SHALL be SYNC_STAGES+DEBOUNCE_CYCLES edges from a clean sw_n edge to the sw_press/sw_release edge.
REQ-019 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); counter SHALL never wrap, saturating is not needed because the FSM exits at terminal count.
REQ-020 On any sw_press pulse, mode SHALL load lowest pressing index+1 and mode_strobe SHALL pulse the same edge.
REQ-021 Simultaneous presses: lowest index wins, matching the led block's sw[1]>sw[2]>sw[3] priority; one mode_strobe only.
REQ-022 Release SHALL NOT change mode; mode holds until the next press.
REQ-023 Keys SHALL be independent; a bouncing key SHALL NOT affect another key's counter or state.
REQ-024 A key held low through reset deassertion SHALL be reported as a new press after full latency.

Reset
REQ-025 With rst high at a clk edge, all FSMs SHALL go to IDLE and counters to 0.
REQ-026 The same reset edge SHALL load synchronizer flops with 1 (released) and set sw_level=0, sw_press=0, sw_release=0, mode=0, mode_strobe=0.
REQ-027 Reset mid-debounce SHALL discard partial counts; no pulse SHALL be emitted for the aborted transition.

Configuration
REQ-028 Macro SW_KEY_RELEASE_EN defined: sw_release SHALL be driven per REQ-017.
REQ-029 Macro SW_KEY_RELEASE_EN undefined: sw_release SHALL be constant 0, and the FSM SHALL still debounce release for sw_level correctness.

Structure
REQ-030 Package sw_key_pkg SHALL hold the key FSM state enum, the mode codes MODE_NONE=0..MODE_K3=3 and a default debounce constant.
REQ-031 Per-key logic SHALL be sub-module sw_key_chan (sync, counter, FSM, level/press/release), instantiated NUM_KEYS times.
REQ-032 The top level SHALL hold only the mode priority encode and registers.

Verification (NUM_KEYS=3, DEBOUNCE_CYCLES=8, SYNC_STAGES=2)
REQ-033 Clean press: sw_n[0] 1->0 held -> sw_press[0] high exactly 10th edge, sw_level[0]=1, mode=1, mode_strobe pulse same edge.
REQ-034 Bounce: sw_n[1] low 5 cycles, high 1, low 20 -> single sw_press[1] 10 edges after final fall; none earlier.
REQ-035 Simultaneous press: sw_n[2:1] fall same cycle -> sw_press=3'b110 on one edge, mode=2, one strobe.
REQ-036 Release: after REQ-033, sw_n[0] rises -> sw_release[0] 10 edges later if SW_KEY_RELEASE_EN, else stays 0; mode stays 1 in both builds.
REQ-037 Reset mid-debounce: rst for 1 cycle at count 5 of a press -> no pulse; key still low -> press 10 edges after rst drop.
